// File: rtl/interrupt_sequencer_pkg.sv
// Shared types for the interrupt entry / RTI return sequencer: FSM states,
// data-memory address-source encodings and the flag register width.
package isr_pkg;

   localparam int CCR_W  = 3;
   localparam int DATA_W = 16;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      DRAIN    = 4'd1,
      PUSH_PCH = 4'd2,
      PUSH_PCL = 4'd3,
      PUSH_CCR = 4'd4,
      VEC_H    = 4'd5,
      VEC_L    = 4'd6,
      JUMP     = 4'd7,
      RDRAIN   = 4'd8,
      POP_CCR  = 4'd9,
      POP_PCL  = 4'd10,
      POP_PCH  = 4'd11,
      RESUME   = 4'd12
   } state_t;

   typedef enum logic [1:0] {
      SEL_SP   = 2'd0,
      SEL_SP1  = 2'd1,
      SEL_VEC0 = 2'd2,
      SEL_VEC1 = 2'd3
   } addr_sel_t;

   function automatic logic is_push_state(input state_t s);
      return (s == PUSH_PCH) || (s == PUSH_PCL) || (s == PUSH_CCR);
   endfunction

   function automatic logic is_pop_state(input state_t s);
      return (s == POP_CCR) || (s == POP_PCL) || (s == POP_PCH);
   endfunction

   function automatic logic is_mem_state(input state_t s);
      return is_push_state(s) || is_pop_state(s) || (s == VEC_H) || (s == VEC_L);
   endfunction

endpackage

// File: rtl/interrupt_sequencer_int_sync_edge.sv
// Two-flop synchronizer for the asynchronous interrupt pin followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module int_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise_pulse
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign rise_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Hardware interrupt entry (drain, push PC/CCR, vector fetch, jump) and RTI
// return (drain, pop CCR/PC, restore) sequencer owning the data-memory port.
//
// Memory handshake: mem_req is held high with mem_we/mem_addr_sel/mem_wdata
// stable until a cycle where mem_req=1 and mem_ack=1; that cycle completes the
// access (read data captured, sp_dec/sp_inc pulse combinationally), and
// mem_req is low for the following cycle before the next access starts.
module interrupt_sequencer
   import isr_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              interrupt,
   input  logic              pipe_empty,
   input  logic              rti_exec,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [CCR_W-1:0]  ccr_in,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_fetch,
   output logic              mem_req,
   output logic              mem_we,
   output logic [1:0]        mem_addr_sel,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              sp_dec,
   output logic              sp_inc,
   output logic              pc_load,
   output logic [PC_W-1:0]   pc_out,
   output logic              ccr_load,
   output logic [CCR_W-1:0]  ccr_out,
   output logic              in_isr,
   output state_t            dbg_state,
   output logic              dbg_pending
);

   logic int_rise;

   int_sync_edge u_sync (
      .clk       (clk),
      .rst       (rst),
      .async_in  (interrupt),
      .rise_pulse(int_rise)
   );

   state_t            state_q, state_d;
   logic              pending_q, pending_d;
   logic              in_isr_q, in_isr_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [CCR_W-1:0]  ccr_q, ccr_d;

   logic              stall_q, stall_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   addr_sel_t         sel_q, sel_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              pc_load_q, pc_load_d;
   logic [PC_W-1:0]   pc_out_q, pc_out_d;
   logic              ccr_load_q, ccr_load_d;
   logic [CCR_W-1:0]  ccr_out_q, ccr_out_d;

   logic              ack_ok;
   logic [31:0]       pc_ext;
   logic [31:0]       word_d;

   // mem_req is only ever high inside a memory state, so this also filters stray acks.
   assign ack_ok = mem_req_q & mem_ack;
   assign pc_ext = 32'(pc_in);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      in_isr_d  = in_isr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      ccr_d     = ccr_q;

      // A single pending bit naturally merges any further edges.
      if (int_rise) pending_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (in_isr_q && rti_exec)                 state_d = RDRAIN;
            else if (start && pending_q && !in_isr_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (pipe_empty) begin
               state_d   = PUSH_PCH;
               pending_d = 1'b0;
               hi_d      = pc_ext[31:16];
               lo_d      = pc_ext[15:0];
               ccr_d     = ccr_in;
            end
         end
         RDRAIN:   if (pipe_empty) state_d = POP_CCR;
         PUSH_PCH: if (ack_ok) state_d = PUSH_PCL;
         PUSH_PCL: if (ack_ok) state_d = PUSH_CCR;
         PUSH_CCR: if (ack_ok) state_d = VEC_H;
         VEC_H: begin
            if (ack_ok) begin
               hi_d    = mem_rdata;
               state_d = VEC_L;
            end
         end
         VEC_L: begin
            if (ack_ok) begin
               lo_d    = mem_rdata;
               state_d = JUMP;
            end
         end
         JUMP: state_d = IDLE;
         POP_CCR: begin
            if (ack_ok) begin
               ccr_d   = mem_rdata[CCR_W-1:0];
               state_d = POP_PCL;
            end
         end
         POP_PCL: begin
            if (ack_ok) begin
               lo_d    = mem_rdata;
               state_d = POP_PCH;
            end
         end
         POP_PCH: begin
            if (ack_ok) begin
               hi_d    = mem_rdata;
               state_d = RESUME;
            end
         end
         // An interrupt queued during the ISR goes straight into a new drain.
         RESUME: state_d = (start && pending_q) ? DRAIN : IDLE;
         default: state_d = IDLE;
      endcase

      if (state_d == JUMP)   in_isr_d = 1'b1;
      if (state_d == RESUME) in_isr_d = 1'b0;
   end

   // Output decode from the next state, so registered outputs line up with state_q.
   always_comb begin
      word_d     = {hi_d, lo_d};
      stall_d    = (state_d != IDLE);
      mem_req_d  = is_mem_state(state_d) && !ack_ok;
      mem_we_d   = is_push_state(state_d);
      sel_d      = SEL_SP;
      wdata_d    = '0;
      pc_load_d  = 1'b0;
      pc_out_d   = '0;
      ccr_load_d = 1'b0;
      ccr_out_d  = '0;

      unique case (state_d)
         PUSH_PCH: wdata_d = hi_d;
         PUSH_PCL: wdata_d = lo_d;
         PUSH_CCR: wdata_d = {{(DATA_W-CCR_W){1'b0}}, ccr_d};
         VEC_H:    sel_d   = SEL_VEC0;
         VEC_L:    sel_d   = SEL_VEC1;
         POP_CCR, POP_PCL, POP_PCH: sel_d = SEL_SP1;
         JUMP: begin
            pc_load_d = 1'b1;
            pc_out_d  = word_d[PC_W-1:0];
         end
         RESUME: begin
            pc_load_d  = 1'b1;
            pc_out_d   = word_d[PC_W-1:0];
            ccr_load_d = 1'b1;
            ccr_out_d  = ccr_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         pending_q  <= 1'b0;
         in_isr_q   <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         ccr_q      <= '0;
         stall_q    <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         sel_q      <= SEL_SP;
         wdata_q    <= '0;
         pc_load_q  <= 1'b0;
         pc_out_q   <= '0;
         ccr_load_q <= 1'b0;
         ccr_out_q  <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         in_isr_q   <= in_isr_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         ccr_q      <= ccr_d;
         stall_q    <= stall_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
         sel_q      <= sel_d;
         wdata_q    <= wdata_d;
         pc_load_q  <= pc_load_d;
         pc_out_q   <= pc_out_d;
         ccr_load_q <= ccr_load_d;
         ccr_out_q  <= ccr_out_d;
      end
   end

   assign stall_fetch  = stall_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr_sel = sel_q;
   assign mem_wdata    = wdata_q;
   assign sp_dec       = ack_ok && is_push_state(state_q);
   assign sp_inc       = ack_ok && is_pop_state(state_q);
   assign pc_load      = pc_load_q;
   assign pc_out       = pc_out_q;
   assign ccr_load     = ccr_load_q;
   assign ccr_out      = ccr_out_q;
   assign in_isr       = in_isr_q;
   assign dbg_state    = state_q;
   assign dbg_pending  = pending_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: entry, RTI, wait states, merging,
// start gating and asynchronous reset in the middle of a vector fetch.
module tb_interrupt_sequencer;
   import isr_pkg::*;

   localparam int PC_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start, interrupt, pipe_empty, rti_exec, mem_ack;
   logic [PC_W-1:0]   pc_in;
   logic [CCR_W-1:0]  ccr_in;
   logic [15:0]       mem_rdata;
   logic              stall_fetch, mem_req, mem_we, sp_dec, sp_inc;
   logic              pc_load, ccr_load, in_isr, dbg_pending;
   logic [1:0]        mem_addr_sel;
   logic [15:0]       mem_wdata;
   logic [PC_W-1:0]   pc_out;
   logic [CCR_W-1:0]  ccr_out;
   state_t            dbg_state;

   int checks = 0;
   int errors = 0;

   interrupt_sequencer #(.PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .start(start), .interrupt(interrupt),
      .pipe_empty(pipe_empty), .rti_exec(rti_exec), .pc_in(pc_in),
      .ccr_in(ccr_in), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_fetch(stall_fetch), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .mem_wdata(mem_wdata), .sp_dec(sp_dec),
      .sp_inc(sp_inc), .pc_load(pc_load), .pc_out(pc_out),
      .ccr_load(ccr_load), .ccr_out(ccr_out), .in_isr(in_isr),
      .dbg_state(dbg_state), .dbg_pending(dbg_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input state_t exp);
      chk(tag, 32'(dbg_state), 32'(exp));
   endtask

   // One memory access: wait for the request, check its attributes, hold off
   // the ack for `waits` cycles, ack, check the SP pulse, then check the gap.
   task automatic mem_access(input string tag, input logic we, input logic [1:0] sel,
                             input logic [15:0] wd, input logic [15:0] rd,
                             input int waits, input logic dec, input logic inc);
      int n = 0;
      while (!mem_req && n < 8) begin
         tick();
         n++;
      end
      chk({tag, ".req"}, 32'(mem_req), 32'd1);
      chk({tag, ".we"}, 32'(mem_we), 32'(we));
      chk({tag, ".sel"}, 32'(mem_addr_sel), 32'(sel));
      if (we) chk({tag, ".wdata"}, 32'(mem_wdata), 32'(wd));
      for (int i = 0; i < waits; i++) begin
         tick();
         chk({tag, ".hold_req"}, 32'(mem_req), 32'd1);
         chk({tag, ".hold_sel"}, 32'(mem_addr_sel), 32'(sel));
         chk({tag, ".hold_wdata"}, 32'(mem_wdata), 32'(wd));
         chk({tag, ".hold_sp"}, 32'({sp_dec, sp_inc}), 32'd0);
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      #1;
      chk({tag, ".sp_dec"}, 32'(sp_dec), 32'(dec));
      chk({tag, ".sp_inc"}, 32'(sp_inc), 32'(inc));
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 16'h0;
      #1;
      chk({tag, ".gap"}, 32'(mem_req), 32'd0);
      chk({tag, ".gap_sp"}, 32'({sp_dec, sp_inc}), 32'd0);
   endtask

   task automatic int_edge();
      interrupt = 1'b0;
      tick(3);
      interrupt = 1'b1;
      tick(3);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; interrupt = 1'b0; pipe_empty = 1'b0;
      rti_exec = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
      pc_in = '0; ccr_in = '0;
      tick(2);
      chk_state("reset.state", IDLE);
      chk("reset.outs", 32'({stall_fetch, mem_req, mem_we, sp_dec, sp_inc, pc_load, ccr_load, in_isr}), 32'd0);
      chk("reset.pending", 32'(dbg_pending), 32'd0);
      rst = 1'b1;
      tick();

      // RTI outside an ISR and a stray ack are both ignored.
      start = 1'b1; rti_exec = 1'b1; mem_ack = 1'b1;
      #1;
      chk("stray.sp", 32'({sp_dec, sp_inc}), 32'd0);
      tick();
      rti_exec = 1'b0; mem_ack = 1'b0;
      chk_state("stray.state", IDLE);
      chk("stray.stall", 32'(stall_fetch), 32'd0);

      // Interrupt entry.
      pc_in = 32'h0000_0123; ccr_in = 3'b101;
      interrupt = 1'b1;
      tick(2);
      chk("e1.pending_early", 32'(dbg_pending), 32'd0);
      tick();
      chk("e1.pending", 32'(dbg_pending), 32'd1);
      chk("e1.idle_stall", 32'(stall_fetch), 32'd0);
      tick();
      chk_state("e1.drain", DRAIN);
      chk("e1.drain_stall", 32'(stall_fetch), 32'd1);
      tick();
      chk_state("e1.drain_wait", DRAIN);
      pipe_empty = 1'b1;
      tick();
      chk_state("e1.push_pch", PUSH_PCH);
      chk("e1.pending_clr", 32'(dbg_pending), 32'd0);
      mem_access("e1.pch", 1'b1, 2'd0, 16'h0000, 16'h0, 0, 1'b1, 1'b0);
      mem_access("e1.pcl", 1'b1, 2'd0, 16'h0123, 16'h0, 0, 1'b1, 1'b0);
      mem_access("e1.ccr", 1'b1, 2'd0, 16'h0005, 16'h0, 0, 1'b1, 1'b0);
      mem_access("e1.vech", 1'b0, 2'd2, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
      mem_access("e1.vecl", 1'b0, 2'd3, 16'h0000, 16'h0200, 0, 1'b0, 1'b0);
      chk_state("e1.jump", JUMP);
      chk("e1.pc_load", 32'(pc_load), 32'd1);
      chk("e1.pc_out", 32'(pc_out), 32'h0000_0200);
      chk("e1.jump_stall", 32'(stall_fetch), 32'd1);
      chk("e1.jump_in_isr", 32'(in_isr), 32'd1);
      tick();
      chk_state("e1.idle", IDLE);
      chk("e1.post", 32'({stall_fetch, pc_load, in_isr}), 32'b001);

      // RTI return.
      rti_exec = 1'b1;
      tick();
      rti_exec = 1'b0;
      chk_state("r1.rdrain", RDRAIN);
      chk("r1.stall", 32'(stall_fetch), 32'd1);
      mem_access("r1.ccr", 1'b0, 2'd1, 16'h0, 16'h0005, 0, 1'b0, 1'b1);
      mem_access("r1.pcl", 1'b0, 2'd1, 16'h0, 16'h0123, 0, 1'b0, 1'b1);
      mem_access("r1.pch", 1'b0, 2'd1, 16'h0, 16'h0000, 0, 1'b0, 1'b1);
      chk_state("r1.resume", RESUME);
      chk("r1.loads", 32'({pc_load, ccr_load}), 32'b11);
      chk("r1.pc_out", 32'(pc_out), 32'h0000_0123);
      chk("r1.ccr_out", 32'(ccr_out), 32'd5);
      chk("r1.in_isr", 32'(in_isr), 32'd0);
      tick();
      chk_state("r1.idle", IDLE);
      chk("r1.post", 32'({stall_fetch, pc_load, ccr_load}), 32'd0);

      // Entry with wait states on the PC low-word push and a 17-bit PC.
      pc_in = 32'h0001_ABCD; ccr_in = 3'b010;
      int_edge();
      chk("e2.pending", 32'(dbg_pending), 32'd1);
      tick();
      chk_state("e2.drain", DRAIN);
      tick();
      mem_access("e2.pch", 1'b1, 2'd0, 16'h0001, 16'h0, 0, 1'b1, 1'b0);
      mem_access("e2.pcl", 1'b1, 2'd0, 16'hABCD, 16'h0, 4, 1'b1, 1'b0);
      mem_access("e2.ccr", 1'b1, 2'd0, 16'h0002, 16'h0, 0, 1'b1, 1'b0);
      mem_access("e2.vech", 1'b0, 2'd2, 16'h0, 16'h0001, 0, 1'b0, 1'b0);
      mem_access("e2.vecl", 1'b0, 2'd3, 16'h0, 16'h8000, 0, 1'b0, 1'b0);
      chk("e2.pc_out", 32'(pc_out), 32'h0001_8000);
      tick();
      chk("e2.in_isr", 32'(in_isr), 32'd1);

      // Two edges during the ISR merge into one queued interrupt.
      int_edge();
      int_edge();
      chk("m.pending", 32'(dbg_pending), 32'd1);
      chk_state("m.idle_in_isr", IDLE);
      rti_exec = 1'b1;
      tick();
      rti_exec = 1'b0;
      chk_state("m.rdrain", RDRAIN);
      mem_access("m.ccr", 1'b0, 2'd1, 16'h0, 16'h0002, 0, 1'b0, 1'b1);
      mem_access("m.pcl", 1'b0, 2'd1, 16'h0, 16'hABCD, 0, 1'b0, 1'b1);
      mem_access("m.pch", 1'b0, 2'd1, 16'h0, 16'h0001, 0, 1'b0, 1'b1);
      chk_state("m.resume", RESUME);
      chk("m.pc_out", 32'(pc_out), 32'h0001_ABCD);
      chk("m.ccr_out", 32'(ccr_out), 32'd2);
      tick();
      chk_state("m.drain_next", DRAIN);
      tick();
      chk_state("m.push", PUSH_PCH);
      chk("m.pending_once", 32'(dbg_pending), 32'd0);
      mem_access("m.pch", 1'b1, 2'd0, 16'h0001, 16'h0, 0, 1'b1, 1'b0);
      mem_access("m.pcl", 1'b1, 2'd0, 16'hABCD, 16'h0, 0, 1'b1, 1'b0);
      mem_access("m.ccr", 1'b1, 2'd0, 16'h0002, 16'h0, 0, 1'b1, 1'b0);
      mem_access("m.vech", 1'b0, 2'd2, 16'h0, 16'h0000, 0, 1'b0, 1'b0);
      tick();
      chk_state("rst.vecl", VEC_L);
      chk("rst.vecl_req", 32'(mem_req), 32'd1);

      // Asynchronous reset in the middle of the vector fetch.
      interrupt = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst.outs", 32'({stall_fetch, mem_req, mem_we, sp_dec, sp_inc, pc_load, ccr_load, in_isr}), 32'd0);
      chk("rst.bus", 32'({mem_addr_sel, mem_wdata}), 32'd0);
      chk("rst.pc_out", 32'(pc_out), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      chk_state("rst.idle", IDLE);
      chk("rst.pending", 32'(dbg_pending), 32'd0);
      chk("rst.in_isr", 32'(in_isr), 32'd0);

      // Start gating.
      start = 1'b0;
      int_edge();
      chk("g.pending", 32'(dbg_pending), 32'd1);
      tick(2);
      chk_state("g.held", IDLE);
      chk("g.stall", 32'(stall_fetch), 32'd0);
      start = 1'b1;
      tick();
      chk_state("g.drain", DRAIN);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences the processor's hardware interrupt entry and RTI return.
- Latches the external `interrupt` pin and freezes fetch until the pipeline drains.
- Pushes PC and CCR to the stack through the data-memory port, then loads the ISR address from the vector table.
- On RTI, pops CCR and PC and restores them. Sits beside the fetch stage and arbitrates the data-memory port while active.

Parameters:
- PC_W, 32, PC width; legal range 17..32. Stored as two 16-bit words, hi word zero-padded.
- DATA_W, 16, memory word width. Fixed at 16.
- CCR_W, 3, flag register width (Z,N,C). Zero-extended to 16 bits when pushed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  processor run enable; no sequence begins while 0
- interrupt  in  1  external interrupt pin, asynchronous to clk
- pipe_empty  in  1  processor reports no instruction in flight past fetch
- rti_exec  in  1  one-cycle pulse: RTI reached decode
- pc_in  in  PC_W  PC of next unexecuted instruction
- ccr_in  in  CCR_W  current flags
- mem_ack  in  1  memory completed the current access
- mem_rdata  in  16  read data, valid with mem_ack
- stall_fetch  out  1  freeze PC and inject NOPs
- mem_req  out  1  memory access request
- mem_we  out  1  1=write, 0=read
- mem_addr_sel  out  2  address source: 0=SP, 1=SP+1, 2=vector word 0, 3=vector word 1
- mem_wdata  out  16  write data
- sp_dec  out  1  one-cycle pulse: SP decrements after a push
- sp_inc  out  1  one-cycle pulse: SP increments after a pop
- pc_load  out  1  one-cycle pulse: load pc_out into PC
- pc_out  out  PC_W  new PC value
- ccr_load  out  1  one-cycle pulse: load ccr_out
- ccr_out  out  CCR_W  restored flags
- in_isr  out  1  an ISR is executing

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pending=0, in_isr=0, all outputs 0, internal hi/lo/ccr holding registers 0.
  - Reset mid-sequence abandons the sequence without completing the memory access.
- Interrupt capture:
  - `interrupt` passes through a 2-FF synchronizer, then a rising-edge detector.
  - An edge sets `pending`. Edge-to-pending latency: 3 clk.
  - `pending` is cleared on entry to PUSH_PCH.
  - Edges arriving while pending=1 or in_isr=1 are merged: at most one interrupt is queued.
- IDLE:
  - If in_isr=1 and rti_exec=1 → RDRAIN. RTI has priority over pending.
  - Else if start=1, pending=1, in_isr=0 → DRAIN.
- DRAIN / RDRAIN:
  - stall_fetch=1.
  - Wait for pipe_empty=1, then → PUSH_PCH (from DRAIN) or POP_CCR (from RDRAIN).
  - pc_in and ccr_in are sampled in the cycle the state leaves DRAIN.
- Memory handshake, all memory states:
  - mem_req=1 with mem_we, mem_addr_sel and mem_wdata held stable until mem_ack=1.
  - On the ack cycle the FSM advances, and the SP pulse for that access fires in the same cycle.
  - mem_req drops for at least one cycle between accesses (one-cycle gap).
- Push sequence (writes at SP, sp_dec on each ack):
  - PUSH_PCH writes PC hi.
  - PUSH_PCL writes PC lo.
  - PUSH_CCR writes zero-extended CCR.
- Vector fetch (reads, no SP pulse):
  - VEC_H reads via addr_sel=2 into hi.
  - VEC_L reads via addr_sel=3 into lo.
  - → JUMP.
- JUMP (1 cycle):
  - pc_out={hi,lo} truncated to PC_W, pc_load=1, in_isr←1.
  - stall_fetch stays 1 this cycle and is 0 from the next cycle → IDLE.
- Pop sequence (reads at SP+1, sp_inc on each ack):
  - POP_CCR → ccr register.
  - POP_PCL → lo.
  - POP_PCH → hi.
  - → RESUME.
- RESUME (1 cycle):
  - pc_load=1, ccr_load=1, in_isr←0 → IDLE.
  - An interrupt pending at RESUME is serviced starting the next cycle.
- stall_fetch=1 in every state except IDLE.
- Boundary cases:
  - start=0 mid-sequence does not abort; the sequence completes.
  - rti_exec with in_isr=0 is ignored.
  - mem_ack outside a memory state is ignored.

Decomposition:
- Package `isr_pkg`:
  - state enum (IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_CCR, VEC_H, VEC_L, JUMP, RDRAIN, POP_CCR, POP_PCL, POP_PCH, RESUME)
  - mem_addr_sel encodings
  - CCR_W constant
- One sub-module, `int_sync_edge`: 2-FF synchronizer plus rising-edge pulse, with the same rst.

Test Plan:
- Interrupt entry: start=1, pc_in=32'h0000_0123, ccr_in=3'b101, interrupt pulse, pipe_empty=1 two cycles after DRAIN, mem_ack=1 immediately, vector words 16'h0000/16'h0200 → writes 0x0000, 0x0123, 0x0005 with 3 sp_dec pulses; pc_load with pc_out=0x0000_0200; in_isr=1.
- RTI return: in_isr=1, rti_exec pulse, pops return 0x0005, 0x0123, 0x0000 → 3 sp_inc pulses; RESUME with pc_out=0x0000_0123, ccr_out=3'b101, in_isr=0.
- Wait states: mem_ack delayed 4 cycles on PUSH_PCL → mem_req/addr/wdata stable all 4 cycles, only one sp_dec pulse.
- Merge and nesting: two interrupt edges during ISR plus an RTI → exactly one new entry, starting the cycle after RESUME.
- Gating: interrupt edge with start=0 → no DRAIN; set start=1 → entry begins next cycle.
- Reset mid-op: rst=0 during VEC_L → all outputs 0 asynchronously; after release, FSM is IDLE and pending=0.
